i2c_reg_access_arbiter: RTL and testbench
=========================================

// Module: i2c_reg_access_arbiter
// PURPOSE
//  Shares one I2C master between NUM_REQ register-access clients. Grants one client at a
//  time, round-robin. Expands each request into a byte sequence on the master's command
//  interface: register write = addr+reg+data; register read = addr+reg, repeated start,
//  one read byte. Returns read data and error status to the client. Sits between
//  peripheral drivers (sensor/codec init FSMs) and the I2C master.
// PARAMETERS
//  NUM_REQ      2       number of clients, 1..8
//  TIMEOUT_CYC  200000  i_clk cycles allowed per busy-edge wait before abort, >=16
// PORTS
//  i_clk          in   1          system clock
//  i_rst          in   1          async reset, active-high
//  i_req          in   NUM_REQ    request level per client; hold until matching o_done
//  i_req_rw       in   NUM_REQ    0 = register write, 1 = register read
//  i_req_slave    in   7*NUM_REQ  7-bit slave address; client k uses [7k+6:7k]
//  i_req_reg      in   8*NUM_REQ  register index; client k uses [8k+7:8k]
//  i_req_wdata    in   8*NUM_REQ  write data; client k uses [8k+7:8k]
//  o_grant        out  NUM_REQ    one-hot; granted client, held until o_done
//  o_done         out  1          1-cycle pulse, transaction complete
//  o_done_id      out  3          client index for o_done
//  o_rd_data      out  8          read byte; valid with o_done on reads
//  o_err          out  1          with o_done: slave NACK or timeout
//  o_m_enable     out  1          to master i_enable
//  o_m_slave_addr out  7          to master i_slave_addr
//  o_m_rw         out  1          to master i_rw
//  o_m_wr_byte    out  8          to master i_wr_byte
//  i_m_busy       in   1          from master o_busy, same clock domain
//  i_m_rd_byte    in   8          from master o_rd_byte
//  i_m_ack_error  in   1          from master o_ack_error
// BEHAVIOUR
//  Reset: all outputs 0; RR pointer = 0; FSM = IDLE. Reset mid-transfer drops o_m_enable
//   at once, with no o_done. The master is reset by the same i_rst.
//  Edges: busy_rise / busy_fall come from a registered copy of i_m_busy (reset 0).
//  Arbitration (IDLE, i_m_busy=0): pick the first asserted i_req at index >= ptr, wrapping.
//   o_grant is set next cycle. ptr = winner+1 mod NUM_REQ, updated on o_done.
//   Fields of the winner are latched at grant; later changes by the client are ignored.
//  FSM: IDLE -> CMD_REG -> {WR_DATA | RD_SWITCH} -> FINISH -> DONE -> IDLE.
//   CMD_REG:   enable=1, rw=0, slave=latched, wr_byte=reg. Waits for busy_rise.
//   WR_DATA:   on entry wr_byte=wdata. On the next busy_rise, enable=0, go to FINISH.
//   RD_SWITCH: on entry rw=1 (repeated start). On the next busy_rise, enable=0, go to FINISH.
//   FINISH:    wait for busy_fall. Sample i_m_rd_byte and i_m_ack_error in that cycle.
//   DONE:      o_done=1 for one cycle, with o_done_id, o_rd_data, o_err. o_grant clears the
//              same cycle. Returns to IDLE.
//  o_rd_data holds its value until the next read completes. Writes leave it unchanged.
//  o_err = sampled ack_error OR timeout.
//  Timeout: a counter clears on every state change. If it reaches TIMEOUT_CYC, set enable=0,
//   wait for i_m_busy=0 (no second timeout), then DONE with o_err=1 and o_rd_data unchanged.
//  Master outputs stay stable whenever enable=1. Only the transitions above change them.
//  Requests that arrive while a transaction is active wait. Dropping i_req after grant
//   does not abort the transaction.
//  NUM_REQ=1: o_grant tracks the single client; the pointer stays at 0.
// TESTING
//  1 Client0 write slave 0x1A reg 0x05 data 0x3C, ACK model -> master sees bytes 0x34,0x05,0x3C,
//    stop; o_done, id=0, o_err=0.
//  2 Client1 read slave 0x50 reg 0x10, model returns 0xA5 -> write 0xA0,0x10, Sr, 0xA1, NACK,
//    stop; o_rd_data=0xA5, o_err=0.
//  3 Both i_req high at once, ptr=0 -> grants 0,1,0,1 for 4 back-to-back transactions; no
//    overlap of grants.
//  4 Slave NACKs address 0x2B -> o_done with o_err=1; next request proceeds normally.
//  5 Busy stuck low (master disconnected), TIMEOUT_CYC=64 -> o_done with o_err=1 at ~66
//    cycles; enable=0.
//  6 i_rst asserted in WR_DATA -> all outputs 0 next edge; after release, new request completes.

Source files
------------

// File: rtl/i2c_reg_access_arbiter.sv
`timescale 1ns/1ps
// i2c_reg_access_arbiter: round-robin share of one I2C master among NUM_REQ register clients.
// Latency: grant 1 cycle after request in IDLE; done 1 cycle after the master's final busy fall.
// Backpressure: requests wait in IDLE while a transaction runs or while the master is busy.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_req/_rw/_slave/_reg/_wdata  per-client request level and packed request fields
//   o_grant                       one-hot granted client, held until o_done
//   o_done/_done_id/_rd_data/_err completion pulse with client id, read byte, error flag
//   o_m_* / i_m_*                 command/status interface of the I2C master
module i2c_reg_access_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_rw,
  input  logic [7*NUM_REQ-1:0] i_req_slave,
  input  logic [8*NUM_REQ-1:0] i_req_reg,
  input  logic [8*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_done,
  output logic [2:0]           o_done_id,
  output logic [7:0]           o_rd_data,
  output logic                 o_err,
  output logic                 o_m_enable,
  output logic [6:0]           o_m_slave_addr,
  output logic                 o_m_rw,
  output logic [7:0]           o_m_wr_byte,
  input  logic                 i_m_busy,
  input  logic [7:0]           i_m_rd_byte,
  input  logic                 i_m_ack_error
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_REG,
    S_WR_DATA,
    S_RD_SWITCH,
    S_FINISH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [2:0]         cur_id;
  logic               lat_rw;
  logic [7:0]         lat_wdata;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;

  logic               busy_rise;
  logic               busy_fall;
  logic               timeout;

  assign busy_rise = i_m_busy & ~busy_q;
  assign busy_fall = ~i_m_busy & busy_q;
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Round-robin pick: lowest requesting index at or above ptr, else lowest overall.
  int                 hi_idx;
  int                 any_idx;
  int                 win_idx;
  int                 win_nxt;
  logic               hi_vld;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_rw;
  logic [6:0]         win_slave;
  logic [7:0]         win_reg;
  logic [7:0]         win_wdata;

  always_comb begin
    hi_idx    = 0;
    any_idx   = 0;
    hi_vld    = 1'b0;
    win_vld   = |i_req;
    win_oh    = '0;
    win_rw    = 1'b0;
    win_slave = '0;
    win_reg   = '0;
    win_wdata = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        any_idx = k;
        if (k >= int'(ptr)) begin
          hi_idx = k;
          hi_vld = 1'b1;
        end
      end
    end
    win_idx = hi_vld ? hi_idx : any_idx;
    win_nxt = (win_idx == NUM_REQ - 1) ? 0 : win_idx + 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (k == win_idx) begin
        win_oh[k] = 1'b1;
        win_rw    = i_req_rw[k];
        win_slave = i_req_slave[7*k +: 7];
        win_reg   = i_req_reg[8*k +: 8];
        win_wdata = i_req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      nxt_ptr        <= '0;
      cur_id         <= '0;
      lat_rw         <= 1'b0;
      lat_wdata      <= '0;
      cnt            <= '0;
      busy_q         <= 1'b0;
      o_grant        <= '0;
      o_done         <= 1'b0;
      o_done_id      <= '0;
      o_rd_data      <= '0;
      o_err          <= 1'b0;
      o_m_enable     <= 1'b0;
      o_m_slave_addr <= '0;
      o_m_rw         <= 1'b0;
      o_m_wr_byte    <= '0;
    end else begin
      busy_q <= i_m_busy;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (win_vld && !i_m_busy) begin
            o_grant        <= win_oh;
            cur_id         <= 3'(win_idx);
            nxt_ptr        <= PTR_W'(win_nxt);
            lat_rw         <= win_rw;
            lat_wdata      <= win_wdata;
            o_m_enable     <= 1'b1;
            o_m_rw         <= 1'b0;
            o_m_slave_addr <= win_slave;
            o_m_wr_byte    <= win_reg;
            state          <= S_CMD_REG;
          end
        end

        // Address+register byte accepted by the master: queue the second phase.
        S_CMD_REG: begin
          if (busy_rise) begin
            cnt <= '0;
            if (lat_rw) begin
              o_m_rw <= 1'b1;
              state  <= S_RD_SWITCH;
            end else begin
              o_m_wr_byte <= lat_wdata;
              state       <= S_WR_DATA;
            end
          end else if (timeout) begin
            cnt        <= '0;
            o_m_enable <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Second phase accepted: drop enable so the master stops after this byte.
        S_WR_DATA, S_RD_SWITCH: begin
          if (busy_rise) begin
            cnt        <= '0;
            o_m_enable <= 1'b0;
            state      <= S_FINISH;
          end else if (timeout) begin
            cnt        <= '0;
            o_m_enable <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FINISH: begin
          if (busy_fall) begin
            cnt       <= '0;
            o_done    <= 1'b1;
            o_done_id <= cur_id;
            o_err     <= i_m_ack_error;
            if (lat_rw) begin
              o_rd_data <= i_m_rd_byte;
            end
            o_grant   <= '0;
            ptr       <= nxt_ptr;
            state     <= S_DONE;
          end else if (timeout) begin
            cnt        <= '0;
            o_m_enable <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // After a timeout, wait for the master to go quiet; no second timeout here.
        S_DRAIN: begin
          if (!i_m_busy) begin
            o_done    <= 1'b1;
            o_done_id <= cur_id;
            o_err     <= 1'b1;
            o_grant   <= '0;
            ptr       <= nxt_ptr;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          o_done    <= 1'b0;
          o_done_id <= '0;
          o_err     <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_access_arbiter.sv
`timescale 1ns/1ps
// tb_i2c_reg_access_arbiter: directed bench with a cycle-level I2C master model.
// Latency: model accepts a byte one cycle after enable, 8 cycles per byte.
// Backpressure: clients hold request until done, as a peripheral init FSM would.
module tb_i2c_reg_access_arbiter;

  localparam int NREQ     = 2;
  localparam int TO       = 64;
  localparam int BYTE_CYC = 8;
  localparam int LOG_S    = 256;
  localparam int LOG_SR   = 257;
  localparam int LOG_P    = 258;
  localparam int LOG_RD   = 259;
  localparam int M_IDLE   = 0;
  localparam int M_XFER   = 1;
  localparam int M_DEC    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [7*NREQ-1:0] req_slave = '0;
  logic [8*NREQ-1:0] req_reg = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic [2:0]        done_id;
  logic [7:0]        rd_data;
  logic              err;
  logic              m_en;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [7:0]        m_wr_byte;
  logic              m_busy = 1'b0;
  logic [7:0]        m_rd = '0;
  logic              m_ackerr = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_access_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req(req), .i_req_rw(req_rw), .i_req_slave(req_slave),
    .i_req_reg(req_reg), .i_req_wdata(req_wdata),
    .o_grant(grant), .o_done(done), .o_done_id(done_id),
    .o_rd_data(rd_data), .o_err(err),
    .o_m_enable(m_en), .o_m_slave_addr(m_addr), .o_m_rw(m_rw), .o_m_wr_byte(m_wr_byte),
    .i_m_busy(m_busy), .i_m_rd_byte(m_rd), .i_m_ack_error(m_ackerr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Master model: logs start/bytes/stop; busy high while shifting, low one cycle between bytes.
  int         m_log[$];
  int         exp_q[$];
  int         m_st = M_IDLE;
  int         m_cnt = 0;
  logic       m_cur_rw = 1'b0;
  logic       m_disc = 1'b0;
  logic [7:0] m_rd_val = 8'h00;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst || m_disc) begin
        m_busy = 1'b0;
        m_st   = M_IDLE;
      end else begin
        case (m_st)
          M_IDLE: if (m_en) begin
            m_ackerr = (m_addr == 7'h2B);
            m_cur_rw = m_rw;
            m_log.push_back(LOG_S);
            m_log.push_back(int'({m_addr, m_rw}));
            m_log.push_back(m_rw ? LOG_RD : int'(m_wr_byte));
            m_cnt  = 2 * BYTE_CYC;
            m_busy = 1'b1;
            m_st   = M_XFER;
          end
          M_XFER: begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_busy = 1'b0;
              if (m_cur_rw) m_rd = m_rd_val;
              m_st = M_DEC;
            end
          end
          default: begin
            if (m_en) begin
              if (m_rw != m_cur_rw) begin
                m_log.push_back(LOG_SR);
                m_log.push_back(int'({m_addr, m_rw}));
                m_cnt = 2 * BYTE_CYC;
              end else begin
                m_cnt = BYTE_CYC;
              end
              m_log.push_back(m_rw ? LOG_RD : int'(m_wr_byte));
              m_cur_rw = m_rw;
              m_busy   = 1'b1;
              m_st     = M_XFER;
            end else begin
              m_log.push_back(LOG_P);
              m_st = M_IDLE;
            end
          end
        endcase
      end
    end
  end

  task automatic set_client(input int id, input logic rw, input logic [6:0] sl,
                            input logic [7:0] rg, input logic [7:0] wd);
    req_rw[id]             = rw;
    req_slave[7*id +: 7]   = sl;
    req_reg[8*id +: 8]     = rg;
    req_wdata[8*id +: 8]   = wd;
  endtask

  int              lat;
  logic            seen;
  logic [NREQ-1:0] first_grant;
  logic [2:0]      d_id;
  logic            d_err;
  logic [7:0]      d_rd;
  logic            d_en;
  logic [NREQ-1:0] d_grant;

  task automatic do_txn(input int id, input logic rw, input logic [6:0] sl,
                        input logic [7:0] rg, input logic [7:0] wd);
    set_client(id, rw, sl, rg, wd);
    req[id]     = 1'b1;
    lat         = 0;
    seen        = 1'b0;
    first_grant = '0;
    while (!seen && lat < 500) begin
      @(posedge clk); #1;
      lat++;
      if (first_grant == '0) first_grant = grant;
      if (done) begin
        seen    = 1'b1;
        d_id    = done_id;
        d_err   = err;
        d_rd    = rd_data;
        d_en    = m_en;
        d_grant = grant;
      end
    end
    req[id] = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(m_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < m_log.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(m_log[i]), 32'(exp_q[i]));
    m_log.delete();
  endtask

  logic [NREQ-1:0] gseq[4];
  logic [2:0]      dseq[4];
  logic [NREQ-1:0] prev_g;
  int              ndone;
  int              ngr;
  int              overlap;
  int              cyc;
  logic            reached;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(m_en), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: client0 register write
    m_log.delete();
    do_txn(0, 1'b0, 7'h1A, 8'h05, 8'h3C);
    chk("t1_grant", 32'(first_grant), 32'h1);
    chk("t1_id", 32'(d_id), 32'd0);
    chk("t1_err", 32'(d_err), 32'd0);
    chk("t1_en_at_done", 32'(d_en), 32'd0);
    chk("t1_grant_at_done", 32'(d_grant), 32'd0);
    chk("t1_rd_data", 32'(d_rd), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    exp_q = {LOG_S, 'h34, 'h05, 'h3C, LOG_P};
    check_log("t1_log");

    // 2: client1 register read
    m_rd_val = 8'hA5;
    do_txn(1, 1'b1, 7'h50, 8'h10, 8'h00);
    chk("t2_grant", 32'(first_grant), 32'h2);
    chk("t2_id", 32'(d_id), 32'd1);
    chk("t2_err", 32'(d_err), 32'd0);
    chk("t2_rd_data", 32'(d_rd), 32'hA5);
    repeat (3) @(posedge clk);
    #1;
    exp_q = {LOG_S, 'hA0, 'h10, LOG_SR, 'hA1, LOG_RD, LOG_P};
    check_log("t2_log");

    // 3: both clients requesting continuously
    set_client(0, 1'b0, 7'h1A, 8'h07, 8'h99);
    set_client(1, 1'b1, 7'h50, 8'h11, 8'h00);
    m_rd_val = 8'h3E;
    for (int k = 0; k < 4; k++) begin
      gseq[k] = '0;
      dseq[k] = 3'd7;
    end
    ndone = 0; ngr = 0; overlap = 0; cyc = 0; prev_g = '0;
    req = 2'b11;
    while (ndone < 4 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if ($countones(grant) > 1) overlap++;
      if (grant != '0 && prev_g == '0 && ngr < 4) begin
        gseq[ngr] = grant;
        ngr++;
      end
      prev_g = grant;
      if (done) begin
        dseq[ndone] = done_id;
        ndone++;
      end
    end
    req = '0;
    chk("t3_ndone", 32'(ndone), 32'd4);
    chk("t3_overlap", 32'(overlap), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_grant%0d", k), 32'(gseq[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t3_id%0d", k), 32'(dseq[k]), 32'(k % 2));
    end
    chk("t3_rd_data", 32'(rd_data), 32'h3E);
    repeat (3) @(posedge clk);
    #1;
    m_log.delete();

    // 4: address NACK, then a normal transaction
    do_txn(0, 1'b0, 7'h2B, 8'h01, 8'h02);
    chk("t4_id", 32'(d_id), 32'd0);
    chk("t4_err", 32'(d_err), 32'd1);
    chk("t4_rd_kept", 32'(d_rd), 32'h3E);
    repeat (3) @(posedge clk);
    #1;
    do_txn(1, 1'b0, 7'h1A, 8'h02, 8'h55);
    chk("t4b_grant", 32'(first_grant), 32'h2);
    chk("t4b_id", 32'(d_id), 32'd1);
    chk("t4b_err", 32'(d_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    m_log.delete();

    // 5: master disconnected, busy never rises
    m_disc = 1'b1;
    do_txn(0, 1'b0, 7'h1A, 8'h03, 8'h04);
    chk("t5_latency", 32'(lat), 32'd66);
    chk("t5_err", 32'(d_err), 32'd1);
    chk("t5_en", 32'(d_en), 32'd0);
    chk("t5_rd_kept", 32'(d_rd), 32'h3E);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_en_after", 32'(m_en), 32'd0);
    m_disc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_log.delete();

    // 6: reset while the write data byte is queued
    set_client(0, 1'b0, 7'h1A, 8'h05, 8'hC3);
    req[0]  = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(posedge clk); #1;
      if (m_en && m_wr_byte == 8'hC3) reached = 1'b1;
    end
    chk("t6_in_wr_data", 32'(reached), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_en", 32'(m_en), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_rd", 32'(rd_data), 32'd0);
    chk("t6_rst_mout", 32'({m_addr, m_rw, m_wr_byte}), 32'd0);
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_log.delete();
    do_txn(0, 1'b0, 7'h1A, 8'h05, 8'hC3);
    chk("t6_id", 32'(d_id), 32'd0);
    chk("t6_err", 32'(d_err), 32'd0);
    chk("t6_rd", 32'(d_rd), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    exp_q = {LOG_S, 'h34, 'h05, 'hC3, LOG_P};
    check_log("t6_log");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
